// File: rtl/softmax_host_ctrl.sv
// Host-side sequencer for a softmax core: loads one vector into the core BRAM,
// pulses start, waits out the busy window, then streams the results back out.
module softmax_host_ctrl #(
  parameter int DATA_W   = 1028,
  parameter int ADDR_W   = 5,
  parameter int N_ROWS   = 12,
  parameter int OUT_BASE = 12,
  parameter int RD_LAT   = 2,
  parameter int BUSY_TO  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_start,
  input  logic              i_busy,
  output logic              o_ext_cena,
  output logic              o_ext_wea,
  output logic [ADDR_W-1:0] o_ext_addra,
  output logic [DATA_W-1:0] o_ext_dina,
  output logic              o_ext_cenb,
  output logic [ADDR_W-1:0] o_ext_addrb,
  input  logic [DATA_W-1:0] i_ext_doutb,
  output logic              o_done,
  output logic              o_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT_HI, S_WAIT_LO, S_RD_ISSUE, S_RD_WAIT, S_OUT
  } state_t;

  localparam int                CNT_W    = $clog2(BUSY_TO + RD_LAT + 4);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_ROWS - 1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(OUT_BASE);

  state_t            state, state_n;
  logic [ADDR_W-1:0] idx, idx_n;
  logic [CNT_W-1:0]  cnt, cnt_n;

  logic              in_ready_n, cena_n, wea_n, start_n, cenb_n;
  logic              out_valid_n, done_n, err_n;
  logic [ADDR_W-1:0] addra_n, addrb_n;
  logic [DATA_W-1:0] dina_n, out_data_n;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      idx         <= '0;
      cnt         <= '0;
      o_in_ready  <= 1'b0;
      o_ext_cena  <= 1'b0;
      o_ext_wea   <= 1'b0;
      o_ext_addra <= '0;
      o_ext_dina  <= '0;
      o_start     <= 1'b0;
      o_ext_cenb  <= 1'b0;
      o_ext_addrb <= '0;
      o_out_valid <= 1'b0;
      o_out_data  <= '0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      cnt         <= cnt_n;
      o_in_ready  <= in_ready_n;
      o_ext_cena  <= cena_n;
      o_ext_wea   <= wea_n;
      o_ext_addra <= addra_n;
      o_ext_dina  <= dina_n;
      o_start     <= start_n;
      o_ext_cenb  <= cenb_n;
      o_ext_addrb <= addrb_n;
      o_out_valid <= out_valid_n;
      o_out_data  <= out_data_n;
      o_done      <= done_n;
      o_err       <= err_n;
    end
  end

  // Every output is the registered image of a next-value computed here.
  always_comb begin
    state_n     = state;
    idx_n       = idx;
    cnt_n       = cnt;
    cena_n      = 1'b0;
    wea_n       = 1'b0;
    addra_n     = o_ext_addra;
    dina_n      = o_ext_dina;
    start_n     = o_start;
    addrb_n     = o_ext_addrb;
    out_valid_n = o_out_valid;
    out_data_n  = o_out_data;
    done_n      = 1'b0;
    err_n       = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (i_en) begin
          state_n = S_LOAD;
          idx_n   = '0;
        end
      end
      S_LOAD: begin
        if (i_in_valid && o_in_ready) begin
          cena_n  = 1'b1;
          wea_n   = 1'b1;
          addra_n = idx;
          dina_n  = i_in_data;
          idx_n   = idx + ADDR_W'(1);
          if (idx == LAST_IDX) begin
            state_n = S_START;
            cnt_n   = '0;
          end
        end
      end
      S_START: begin
        // First cycle here is the final write; start covers the two after it.
        if (cnt == CNT_W'(2)) begin
          start_n = 1'b0;
          state_n = S_WAIT_HI;
          cnt_n   = '0;
        end else begin
          start_n = 1'b1;
          cnt_n   = cnt + CNT_W'(1);
        end
      end
      S_WAIT_HI: begin
        if (i_busy) begin
          state_n = S_WAIT_LO;
        end else if (cnt == CNT_W'(BUSY_TO - 1)) begin
          err_n   = 1'b1;
          state_n = S_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_WAIT_LO: begin
        if (!i_busy) begin
          state_n = S_RD_ISSUE;
          idx_n   = '0;
        end
      end
      S_RD_ISSUE: begin
        state_n = S_RD_WAIT;
        cnt_n   = '0;
      end
      S_RD_WAIT: begin
        if (cnt == CNT_W'(RD_LAT - 1)) begin
          out_data_n  = i_ext_doutb;
          out_valid_n = 1'b1;
          state_n     = S_OUT;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_OUT: begin
        if (i_out_ready) begin
          out_valid_n = 1'b0;
          idx_n       = idx + ADDR_W'(1);
          if (idx == LAST_IDX) begin
            done_n  = 1'b1;
            state_n = S_IDLE;
          end else begin
            state_n = S_RD_ISSUE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    in_ready_n = (state_n == S_LOAD);
    cenb_n     = (state_n == S_RD_ISSUE);
    if (state_n == S_RD_ISSUE) addrb_n = BASE + idx_n;
  end

endmodule

// File: tb/tb_softmax_host_ctrl.sv
// Directed bench for softmax_host_ctrl with a behavioural BRAM and softmax core.
`timescale 1ns/1ps
module tb_softmax_host_ctrl;

  localparam int DATA_W   = 1028;
  localparam int ADDR_W   = 5;
  localparam int N_ROWS   = 12;
  localparam int OUT_BASE = 12;
  localparam int RD_LAT   = 2;
  localparam int BUSY_TO  = 16;

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b1;
  logic              i_en = 1'b0;
  logic              i_in_valid = 1'b0;
  logic              o_in_ready;
  logic [DATA_W-1:0] i_in_data = '0;
  logic              o_out_valid;
  logic              i_out_ready = 1'b0;
  logic [DATA_W-1:0] o_out_data;
  logic              o_start;
  logic              i_busy = 1'b0;
  logic              o_ext_cena, o_ext_wea, o_ext_cenb, o_done, o_err;
  logic [ADDR_W-1:0] o_ext_addra, o_ext_addrb;
  logic [DATA_W-1:0] o_ext_dina, i_ext_doutb;

  int checks = 0;
  int errors = 0;
  bit core_never = 1'b0;

  softmax_host_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_ROWS(N_ROWS),
    .OUT_BASE(OUT_BASE), .RD_LAT(RD_LAT), .BUSY_TO(BUSY_TO)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_data(i_in_data),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_data(o_out_data),
    .o_start(o_start), .i_busy(i_busy),
    .o_ext_cena(o_ext_cena), .o_ext_wea(o_ext_wea), .o_ext_addra(o_ext_addra),
    .o_ext_dina(o_ext_dina), .o_ext_cenb(o_ext_cenb), .o_ext_addrb(o_ext_addrb),
    .i_ext_doutb(i_ext_doutb), .o_done(o_done), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [DATA_W-1:0] in_word(input int seed, input int r);
    logic [31:0] v;
    v = 32'(seed) * 32'h9E3779B1 + 32'(r) * 32'h01000193 + 32'(r);
    return DATA_W'({33{v}});
  endfunction

  // Stand-in for the softmax arithmetic: any fixed bijection exercises the data path.
  function automatic logic [DATA_W-1:0] golden(input logic [DATA_W-1:0] w);
    return ~w ^ {{(DATA_W-16){1'b0}}, 16'h5A5A};
  endfunction

  // Port A memory, port B read pipeline and event log; cyc stamps the posedge of observation.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] res [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rd_p1 = '0, rd_p2 = '0;
  logic              prev_valid = 1'b0;
  int                cyc = 0;
  int                bad_wr = 0;
  int                wr_addr[$], wr_cyc[$], start_cyc[$], rd_addr[$], rd_cyc[$];
  int                cap_cyc[$], done_cyc[$], err_cyc[$];
  logic [DATA_W-1:0] wr_data[$], out_q[$];

  assign i_ext_doutb = rd_p2;

  always @(posedge i_clk) begin
    cyc        <= cyc + 1;
    prev_valid <= o_out_valid;
    rd_p2      <= rd_p1;
    if (o_ext_cenb) begin
      rd_p1 <= res[o_ext_addrb];
      rd_addr.push_back(int'(o_ext_addrb));
      rd_cyc.push_back(cyc);
    end
    if (o_ext_cena && o_ext_wea) begin
      mem[o_ext_addra] <= o_ext_dina;
      wr_addr.push_back(int'(o_ext_addra));
      wr_data.push_back(o_ext_dina);
      wr_cyc.push_back(cyc);
    end
    if (o_ext_cena !== o_ext_wea && i_rst_n) bad_wr <= bad_wr + 1;
    if (o_start) start_cyc.push_back(cyc);
    if (o_out_valid && !prev_valid) cap_cyc.push_back(cyc);
    if (o_out_valid && i_out_ready) out_q.push_back(o_out_data);
    if (o_done) done_cyc.push_back(cyc);
    if (o_err) err_cyc.push_back(cyc);
  end

  initial begin
    forever begin
      @(negedge i_clk);
      if (o_start === 1'b1 && !core_never) begin
        repeat (4) @(negedge i_clk);
        i_busy = 1'b1;
        for (int r = 0; r < N_ROWS; r++) res[OUT_BASE + r] = golden(mem[r]);
        repeat (5) @(negedge i_clk);
        i_busy = 1'b0;
      end
    end
  end

  task automatic feed(input int seed, input int stall_after, input bit hold_en);
    int g;
    @(negedge i_clk);
    i_en = 1'b1;
    if (!hold_en) begin
      @(negedge i_clk);
      i_en = 1'b0;
    end
    for (int r = 0; r < N_ROWS; r++) begin
      i_in_valid = 1'b1;
      i_in_data  = in_word(seed, r);
      g = 0;
      while (o_in_ready !== 1'b1 && g < 20) begin
        @(negedge i_clk);
        g++;
      end
      checks++;
      if (o_in_ready !== 1'b1) begin
        errors++;
        $display("FAIL load_ready word %0d: o_in_ready=%b required 1", r, o_in_ready);
      end
      @(negedge i_clk);
      if (r == stall_after) begin
        i_in_valid = 1'b0;
        repeat (3) @(negedge i_clk);
      end
    end
    i_in_valid = 1'b0;
    i_en = 1'b0;
  endtask

  task automatic wait_end(input string name, input int budget);
    int n, d0, e0;
    n = 0;
    d0 = done_cyc.size();
    e0 = err_cyc.size();
    while (done_cyc.size() == d0 && err_cyc.size() == e0 && n < budget) begin
      @(negedge i_clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_end: no o_done/o_err within %0d cycles", name, budget);
    end
    repeat (3) @(negedge i_clk);
  endtask

  task automatic test_reset;
    #2 i_rst_n = 1'b0;
    #1;
    checks++;
    if ({o_in_ready, o_start, o_ext_cena, o_ext_wea, o_ext_cenb, o_out_valid, o_done, o_err} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 00000000",
               {o_in_ready, o_start, o_ext_cena, o_ext_wea, o_ext_cenb, o_out_valid, o_done, o_err});
    end
    checks++;
    if (o_ext_addra !== '0 || o_ext_addrb !== '0) begin
      errors++;
      $display("FAIL reset_addr: addra=%h addrb=%h required 0", o_ext_addra, o_ext_addrb);
    end
    checks++;
    if (o_ext_dina !== '0 || o_out_data !== '0) begin
      errors++;
      $display("FAIL reset_data: dina=%h out=%h required 0", o_ext_dina[63:0], o_out_data[63:0]);
    end
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);
    checks++;
    if (o_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: o_in_ready=%b required 0", o_in_ready);
    end
  endtask

  task automatic test_nominal;
    int w0, s0, r0, o0, d0, e0, b0;
    logic [DATA_W-1:0] exp_w;
    i_out_ready = 1'b1;
    w0 = wr_addr.size(); s0 = start_cyc.size(); r0 = rd_addr.size();
    o0 = out_q.size(); d0 = done_cyc.size(); e0 = err_cyc.size(); b0 = bad_wr;
    feed(0, -1, 1'b0);
    wait_end("nominal", 400);
    checks++;
    if (wr_addr.size() - w0 != N_ROWS) begin
      errors++;
      $display("FAIL nom_wr_count: got %0d required %0d", wr_addr.size() - w0, N_ROWS);
    end
    for (int r = 0; r < N_ROWS && w0 + r < wr_addr.size(); r++) begin
      exp_w = in_word(0, r);
      checks++;
      if (wr_addr[w0 + r] != r || wr_data[w0 + r] !== exp_w) begin
        errors++;
        $display("FAIL nom_write[%0d]: addr=%0d data=%h required addr=%0d data=%h",
                 r, wr_addr[w0 + r], wr_data[w0 + r][63:0], r, exp_w[63:0]);
      end
    end
    checks++;
    if (bad_wr != b0) begin
      errors++;
      $display("FAIL nom_cena_wea: %0d split cycles required 0", bad_wr - b0);
    end
    checks++;
    if (start_cyc.size() - s0 != 2 || wr_cyc.size() < w0 + N_ROWS ||
        start_cyc[s0] != wr_cyc[w0 + N_ROWS - 1] + 1 || start_cyc[s0 + 1] != start_cyc[s0] + 1) begin
      errors++;
      $display("FAIL nom_start: %0d start cycles, required 2 directly after the last write",
               start_cyc.size() - s0);
    end
    checks++;
    if (rd_addr.size() - r0 != N_ROWS) begin
      errors++;
      $display("FAIL nom_rd_count: got %0d required %0d", rd_addr.size() - r0, N_ROWS);
    end
    for (int i = 0; i < N_ROWS && r0 + i < rd_addr.size(); i++) begin
      checks++;
      if (rd_addr[r0 + i] != OUT_BASE + i) begin
        errors++;
        $display("FAIL nom_rd_addr[%0d]: got %0d required %0d", i, rd_addr[r0 + i], OUT_BASE + i);
      end
    end
    for (int i = 0; i < N_ROWS; i++) begin
      exp_w = golden(in_word(0, i));
      checks++;
      if (o0 + i >= out_q.size() || out_q[o0 + i] !== exp_w) begin
        errors++;
        $display("FAIL nom_out[%0d]: got %0d words, word low bits %h required %h", i,
                 out_q.size() - o0, (o0 + i < out_q.size()) ? out_q[o0 + i][63:0] : 64'hx, exp_w[63:0]);
      end
    end
    checks++;
    if (done_cyc.size() - d0 != 1 || err_cyc.size() != e0) begin
      errors++;
      $display("FAIL nom_status: done=%0d err=%0d required done=1 err=0",
               done_cyc.size() - d0, err_cyc.size() - e0);
    end
  endtask

  task automatic test_stall;
    int w0, o0;
    logic [DATA_W-1:0] exp_w;
    i_out_ready = 1'b1;
    w0 = wr_addr.size(); o0 = out_q.size();
    feed(1, 5, 1'b1);  // i_en held high throughout the load as well
    wait_end("stall", 400);
    checks++;
    if (wr_addr.size() - w0 != N_ROWS) begin
      errors++;
      $display("FAIL stall_wr_count: got %0d required %0d", wr_addr.size() - w0, N_ROWS);
    end
    for (int r = 1; r < N_ROWS && w0 + r < wr_cyc.size(); r++) begin
      checks++;
      if (wr_addr[w0 + r] != r || wr_cyc[w0 + r] - wr_cyc[w0 + r - 1] != ((r == 6) ? 4 : 1)) begin
        errors++;
        $display("FAIL stall_write[%0d]: addr=%0d gap=%0d required addr=%0d gap=%0d", r,
                 wr_addr[w0 + r], wr_cyc[w0 + r] - wr_cyc[w0 + r - 1], r, (r == 6) ? 4 : 1);
      end
    end
    for (int i = 0; i < N_ROWS; i += 11) begin
      exp_w = golden(in_word(1, i));
      checks++;
      if (o0 + i >= out_q.size() || out_q[o0 + i] !== exp_w) begin
        errors++;
        $display("FAIL stall_out[%0d]: required low bits %h", i, exp_w[63:0]);
      end
    end
  endtask

  task automatic test_backpressure;
    int r0, c0, o0, g;
    logic [DATA_W-1:0] exp_w;
    i_out_ready = 1'b0;
    r0 = rd_cyc.size(); c0 = cap_cyc.size(); o0 = out_q.size();
    feed(2, -1, 1'b0);
    g = 0;
    while (o_out_valid !== 1'b1 && g < 100) begin
      @(negedge i_clk);
      g++;
    end
    exp_w = golden(in_word(2, 0));
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (o_out_valid !== 1'b1 || o_out_data !== exp_w) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid=%b data=%h required valid=1 data=%h",
                 k, o_out_valid, o_out_data[63:0], exp_w[63:0]);
      end
      @(negedge i_clk);
    end
    checks++;
    if (rd_cyc.size() - r0 != 1) begin
      errors++;
      $display("FAIL bp_one_read: got %0d reads required 1", rd_cyc.size() - r0);
    end
    i_out_ready = 1'b1;
    wait_end("bp", 400);
    for (int i = 0; i < N_ROWS; i++) begin
      checks++;
      if (r0 + i >= rd_cyc.size() || c0 + i >= cap_cyc.size() ||
          cap_cyc[c0 + i] - rd_cyc[r0 + i] != RD_LAT + 1) begin
        errors++;
        $display("FAIL bp_latency[%0d]: read-to-capture not %0d edges", i, RD_LAT + 1);
      end
    end
    exp_w = golden(in_word(2, N_ROWS - 1));
    checks++;
    if (out_q.size() - o0 != N_ROWS || out_q[o0 + N_ROWS - 1] !== exp_w) begin
      errors++;
      $display("FAIL bp_out: got %0d words required %0d ending in %h", out_q.size() - o0, N_ROWS, exp_w[63:0]);
    end
  endtask

  task automatic test_busy_timeout;
    int s0, e0, d0, r0;
    core_never = 1'b1;
    s0 = start_cyc.size(); e0 = err_cyc.size(); d0 = done_cyc.size(); r0 = rd_cyc.size();
    feed(3, -1, 1'b0);
    wait_end("timeout", 200);
    checks++;
    if (err_cyc.size() - e0 != 1) begin
      errors++;
      $display("FAIL to_err_count: got %0d required 1", err_cyc.size() - e0);
    end
    // Last start cycle is also the WAIT_HI entry edge; error is seen BUSY_TO+1 edges later.
    checks++;
    if (err_cyc.size() <= e0 || start_cyc.size() - s0 != 2 ||
        err_cyc[e0] - start_cyc[s0 + 1] != BUSY_TO + 1) begin
      errors++;
      $display("FAIL to_err_time: distance %0d required %0d",
               (err_cyc.size() > e0 && start_cyc.size() > s0 + 1) ? err_cyc[e0] - start_cyc[s0 + 1] : -1,
               BUSY_TO + 1);
    end
    checks++;
    if (done_cyc.size() != d0 || rd_cyc.size() != r0) begin
      errors++;
      $display("FAIL to_no_done: done=%0d reads=%0d required 0 and 0", done_cyc.size() - d0, rd_cyc.size() - r0);
    end
    checks++;
    if (o_in_ready !== 1'b0 || o_err !== 1'b0 || o_start !== 1'b0) begin
      errors++;
      $display("FAIL to_idle: ready=%b err=%b start=%b required 0 0 0", o_in_ready, o_err, o_start);
    end
    core_never = 1'b0;
  endtask

  task automatic test_reset_midjob;
    int w0, o0;
    logic [DATA_W-1:0] exp_w;
    i_out_ready = 1'b1;
    @(negedge i_clk);
    i_en = 1'b1;
    @(negedge i_clk);
    i_en = 1'b0;
    for (int r = 0; r < 7; r++) begin
      i_in_valid = 1'b1;
      i_in_data  = in_word(9, r);
      @(negedge i_clk);
    end
    i_in_data = in_word(9, 7);
    #2 i_rst_n = 1'b0;
    #1;
    checks++;
    if ({o_in_ready, o_ext_cena, o_ext_wea, o_start, o_ext_cenb, o_out_valid, o_done, o_err} !== 8'h00 ||
        o_ext_addra !== '0 || o_ext_dina !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: ctrl=%b addra=%h required all 0",
               {o_in_ready, o_ext_cena, o_ext_wea, o_start, o_ext_cenb, o_out_valid, o_done, o_err}, o_ext_addra);
    end
    i_in_valid = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    w0 = wr_addr.size(); o0 = out_q.size();
    feed(4, -1, 1'b0);
    wait_end("midrst", 400);
    checks++;
    if (wr_addr.size() - w0 != N_ROWS || wr_addr[w0] != 0 || wr_addr[w0 + N_ROWS - 1] != N_ROWS - 1) begin
      errors++;
      $display("FAIL midrst_fresh: %0d writes, first addr %0d, required %0d from 0",
               wr_addr.size() - w0, (wr_addr.size() > w0) ? wr_addr[w0] : -1, N_ROWS);
    end
    for (int i = 0; i < N_ROWS; i += 4) begin
      exp_w = golden(in_word(4, i));
      checks++;
      if (o0 + i >= out_q.size() || out_q[o0 + i] !== exp_w) begin
        errors++;
        $display("FAIL midrst_out[%0d]: required low bits %h", i, exp_w[63:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_stall();
    test_backpressure();
    test_busy_timeout();
    test_reset_midjob();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete within 200 us");
    $fatal(1, "watchdog");
  end

endmodule
